apb_bus1_arbiter: RTL and testbench
===================================

// Module: apb_bus1_arbiter
// PURPOSE
//  Shares one APB requester port (toward the bus1 peripheral decoder) between two APB completer
//  ports: m0 = axi2apb bridge, m1 = debug/DMI APB master. Round-robin grant, one transfer in flight,
//  registered forwarding in both directions. Sits between the bridges and the bus1 slave mux.
// PARAMETERS
//  ADDR_BITS       32   address width, all ports
//  DATA_BITS       32   pwdata/prdata width; pstrb is DATA_BITS/8
//  TIMEOUT_CYCLES  256  ACCESS-phase watchdog limit (only with APB_ARB_TIMEOUT_EN), >=2
// PORTS
//  i_clk      in   1              clock, all logic on rising edge
//  i_rst      in   1              asynchronous reset, active-high
//  i_m_psel   in   2              per-requester psel, bit n = port n
//  i_m_penable in  2              per-requester penable
//  i_m_paddr  in   2*ADDR_BITS    packed, port n at [n*ADDR_BITS +: ADDR_BITS]
//  i_m_pwrite in   2              per-requester pwrite
//  i_m_pwdata in   2*DATA_BITS    packed write data
//  i_m_pstrb  in   2*DATA_BITS/8  packed byte strobes
//  i_m_pprot  in   2*3            packed pprot
//  o_m_pready out  2              one-cycle completion pulse to granted port
//  o_m_prdata out  DATA_BITS      read data, shared; valid with o_m_pready
//  o_m_pslverr out 1              error, shared; valid with o_m_pready
//  o_s_psel, o_s_penable, o_s_pwrite  out 1   downstream control
//  o_s_paddr  out  ADDR_BITS; o_s_pwdata out DATA_BITS; o_s_pstrb out DATA_BITS/8; o_s_pprot out 3
//  i_s_pready in 1; i_s_prdata in DATA_BITS; i_s_pslverr in 1   downstream response
//  o_grant    out  2              one-hot current owner, 0 in IDLE (debug/perf)
// BEHAVIOUR
//  - Reset (async, i_rst=1): state=IDLE, all outputs 0, last-winner pointer=1 (port 0 wins first tie).
//  - FSM: IDLE -> SETUP -> ACCESS -> RESP -> IDLE. All outputs are registers.
//  - IDLE: request n = i_m_psel[n] (penable ignored). None: stay. One: grant it. Both: grant
//    port != last winner; update pointer. Latch addr/pwrite/pwdata/pstrb/pprot of winner -> SETUP.
//  - SETUP: o_s_psel=1, o_s_penable=0, latched fields driven; next cycle -> ACCESS.
//  - ACCESS: o_s_psel=1, o_s_penable=1; hold until i_s_pready=1; then capture prdata/pslverr,
//    drop o_s_psel/o_s_penable -> RESP.
//  - RESP: o_m_pready[grant]=1 for exactly one cycle with captured data; other bit 0 -> IDLE.
//  - Latency: upstream psel sampled at edge N -> o_s_psel at N+1, o_s_penable at N+2; downstream
//    pready at edge K -> o_m_pready at K+1. Min 4 cycles per transfer, zero-wait slave.
//  - Upstream must hold psel and fields stable until its pready (APB rule); not rechecked after grant.
//  - Back-to-back: requester re-asserting psel in cycle after RESP is arbitrated in that IDLE cycle.
//  - Ungranted requester waits with o_m_pready=0 indefinitely; round-robin bounds wait to 1 transfer.
//  - o_m_prdata/o_m_pslverr hold last value outside RESP; write transfers return captured prdata.
//  - Reset mid-transfer: everything to reset values immediately; no completion issued.
// CONFIGURATION
//  APB_ARB_TIMEOUT_EN defined: counter clears on SETUP->ACCESS, increments each ACCESS cycle; when
//  count reaches TIMEOUT_CYCLES with i_s_pready=0 -> drop o_s_psel/penable, go RESP with
//  o_m_prdata=0, o_m_pslverr=1. i_s_pready in the limit cycle wins (normal completion).
//  Not defined: no counter, ACCESS waits forever; no extra logic.
// TESTING
//  1 m0 read 0x1000, slave pready 1st ACCESS cycle, prdata=0xCAFE0001 -> o_s_psel@N+1, o_m_pready[0]
//    @N+4 with 0xCAFE0001, pslverr=0.
//  2 m0,m1 psel same cycle, 4 rounds each -> grants 0,1,0,1...; each port gets exactly 4 pready pulses.
//  3 m1 write 0x2004 data 0x55AA55AA pstrb 0xF, slave 3 wait states -> o_s_penable held 4 cycles,
//    fields stable, o_m_pready[1] 1 cycle after i_s_pready.
//  4 slave returns pslverr=1 on read -> o_m_pslverr=1 with o_m_pready, next transfer pslverr=0.
//  5 i_rst pulse during ACCESS -> all outputs 0 next edge, no o_m_pready, first tie grants port 0.
//  6 APB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never ready -> psel dropped, o_m_pready with
//    pslverr=1, prdata=0; without macro bench confirms wait persists 1000 cycles.

Source files
------------

// File: rtl/apb_bus1_arbiter.sv
// apb_bus1_arbiter: shares one APB requester port toward the bus1 decoder
// between two APB completer ports (m0 = axi2apb bridge, m1 = debug/DMI).
// Round-robin grant, one transfer in flight, registered in both directions.
// Optional feature macro: APB_ARB_TIMEOUT_EN adds an ACCESS-phase watchdog
// that completes a hung transfer with pslverr=1 and prdata=0.
module apb_bus1_arbiter #(
   parameter int ADDR_BITS      = 32,
   parameter int DATA_BITS      = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic [1:0]                 i_m_psel,
   input  logic [1:0]                 i_m_penable,
   input  logic [2*ADDR_BITS-1:0]     i_m_paddr,
   input  logic [1:0]                 i_m_pwrite,
   input  logic [2*DATA_BITS-1:0]     i_m_pwdata,
   input  logic [2*(DATA_BITS/8)-1:0] i_m_pstrb,
   input  logic [5:0]                 i_m_pprot,
   output logic [1:0]                 o_m_pready,
   output logic [DATA_BITS-1:0]       o_m_prdata,
   output logic                       o_m_pslverr,
   output logic                       o_s_psel,
   output logic                       o_s_penable,
   output logic                       o_s_pwrite,
   output logic [ADDR_BITS-1:0]       o_s_paddr,
   output logic [DATA_BITS-1:0]       o_s_pwdata,
   output logic [DATA_BITS/8-1:0]     o_s_pstrb,
   output logic [2:0]                 o_s_pprot,
   input  logic                       i_s_pready,
   input  logic [DATA_BITS-1:0]       i_s_prdata,
   input  logic                       i_s_pslverr,
   output logic [1:0]                 o_grant
);

   localparam int STRB_BITS = DATA_BITS / 8;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETUP  = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;
   localparam logic [1:0] ST_RESP   = 2'd3;

   logic [1:0]           state_q,     state_d;
   logic                 last_q,      last_d;
   logic [1:0]           grant_q,     grant_d;
   logic                 s_psel_q,    s_psel_d;
   logic                 s_penable_q, s_penable_d;
   logic                 s_pwrite_q,  s_pwrite_d;
   logic [ADDR_BITS-1:0] s_paddr_q,   s_paddr_d;
   logic [DATA_BITS-1:0] s_pwdata_q,  s_pwdata_d;
   logic [STRB_BITS-1:0] s_pstrb_q,   s_pstrb_d;
   logic [2:0]           s_pprot_q,   s_pprot_d;
   logic [DATA_BITS-1:0] cap_rdata_q, cap_rdata_d;
   logic                 cap_err_q,   cap_err_d;
   logic [1:0]           m_pready_q,  m_pready_d;
   logic [DATA_BITS-1:0] m_prdata_q,  m_prdata_d;
   logic                 m_pslverr_q, m_pslverr_d;

   logic [1:0]           req;
   logic                 win;

`ifdef APB_ARB_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
`else
   localparam int unused_timeout_limit = TIMEOUT_CYCLES;
`endif

   // penable from the requesters carries no information for arbitration
   logic unused_penable;
   assign unused_penable = ^i_m_penable;

   // A requester whose pready is currently on the wire still shows psel at
   // that edge; masking it keeps the finished transfer from being re-granted.
   assign req = i_m_psel & ~m_pready_q;

   // Next-state logic: arbitration, downstream phase sequencing, completion
   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      grant_d     = grant_q;
      s_psel_d    = s_psel_q;
      s_penable_d = s_penable_q;
      s_pwrite_d  = s_pwrite_q;
      s_paddr_d   = s_paddr_q;
      s_pwdata_d  = s_pwdata_q;
      s_pstrb_d   = s_pstrb_q;
      s_pprot_d   = s_pprot_q;
      cap_rdata_d = cap_rdata_q;
      cap_err_d   = cap_err_q;
      m_pready_d  = 2'b00;
      m_prdata_d  = m_prdata_q;
      m_pslverr_d = m_pslverr_q;
      win         = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
      cnt_d       = cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (req != 2'b00) begin
               win        = (req == 2'b11) ? ~last_q : req[1];
               last_d     = win;
               grant_d    = win ? 2'b10 : 2'b01;
               s_paddr_d  = win ? i_m_paddr[2*ADDR_BITS-1:ADDR_BITS] : i_m_paddr[ADDR_BITS-1:0];
               s_pwdata_d = win ? i_m_pwdata[2*DATA_BITS-1:DATA_BITS] : i_m_pwdata[DATA_BITS-1:0];
               s_pstrb_d  = win ? i_m_pstrb[2*STRB_BITS-1:STRB_BITS] : i_m_pstrb[STRB_BITS-1:0];
               s_pprot_d  = win ? i_m_pprot[5:3] : i_m_pprot[2:0];
               s_pwrite_d = win ? i_m_pwrite[1] : i_m_pwrite[0];
               state_d    = ST_SETUP;
            end
         end
         ST_SETUP: begin
            s_psel_d = 1'b1;
            state_d  = ST_ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
            cnt_d    = '0;
`endif
         end
         ST_ACCESS: begin
            // the slave's pready only counts once penable is actually driven
            if (!s_penable_q) begin
               s_penable_d = 1'b1;
            end else if (i_s_pready) begin
               s_psel_d    = 1'b0;
               s_penable_d = 1'b0;
               cap_rdata_d = i_s_prdata;
               cap_err_d   = i_s_pslverr;
               state_d     = ST_RESP;
`ifdef APB_ARB_TIMEOUT_EN
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               s_psel_d    = 1'b0;
               s_penable_d = 1'b0;
               cap_rdata_d = '0;
               cap_err_d   = 1'b1;
               state_d     = ST_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
`endif
            end
         end
         default: begin
            m_pready_d  = grant_q;
            m_prdata_d  = cap_rdata_q;
            m_pslverr_d = cap_err_q;
            grant_d     = 2'b00;
            state_d     = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset clears everything and parks the
   // last-winner pointer on port 1 so port 0 wins the first tie
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= ST_IDLE;
         last_q      <= 1'b1;
         grant_q     <= 2'b00;
         s_psel_q    <= 1'b0;
         s_penable_q <= 1'b0;
         s_pwrite_q  <= 1'b0;
         s_paddr_q   <= '0;
         s_pwdata_q  <= '0;
         s_pstrb_q   <= '0;
         s_pprot_q   <= 3'b000;
         cap_rdata_q <= '0;
         cap_err_q   <= 1'b0;
         m_pready_q  <= 2'b00;
         m_prdata_q  <= '0;
         m_pslverr_q <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
         cnt_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         grant_q     <= grant_d;
         s_psel_q    <= s_psel_d;
         s_penable_q <= s_penable_d;
         s_pwrite_q  <= s_pwrite_d;
         s_paddr_q   <= s_paddr_d;
         s_pwdata_q  <= s_pwdata_d;
         s_pstrb_q   <= s_pstrb_d;
         s_pprot_q   <= s_pprot_d;
         cap_rdata_q <= cap_rdata_d;
         cap_err_q   <= cap_err_d;
         m_pready_q  <= m_pready_d;
         m_prdata_q  <= m_prdata_d;
         m_pslverr_q <= m_pslverr_d;
`ifdef APB_ARB_TIMEOUT_EN
         cnt_q       <= cnt_d;
`endif
      end
   end

   assign o_m_pready  = m_pready_q;
   assign o_m_prdata  = m_prdata_q;
   assign o_m_pslverr = m_pslverr_q;
   assign o_s_psel    = s_psel_q;
   assign o_s_penable = s_penable_q;
   assign o_s_pwrite  = s_pwrite_q;
   assign o_s_paddr   = s_paddr_q;
   assign o_s_pwdata  = s_pwdata_q;
   assign o_s_pstrb   = s_pstrb_q;
   assign o_s_pprot   = s_pprot_q;
   assign o_grant     = grant_q;

endmodule

// File: tb/tb_apb_bus1_arbiter.sv
// Bench for apb_bus1_arbiter: behavioural masters and slave, completions
// checked by a scoreboard monitor. Define APB_ARB_TIMEOUT_EN to exercise
// the watchdog with an 8-cycle limit.
module tb_apb_bus1_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;
`ifdef APB_ARB_TIMEOUT_EN
   localparam int TO = 8;
`else
   localparam int TO = 256;
`endif

   logic          i_clk, i_rst;
   logic [1:0]    i_m_psel, i_m_penable, i_m_pwrite;
   logic [2*AW-1:0] i_m_paddr;
   logic [2*DW-1:0] i_m_pwdata;
   logic [2*SW-1:0] i_m_pstrb;
   logic [5:0]    i_m_pprot;
   logic [1:0]    o_m_pready;
   logic [DW-1:0] o_m_prdata;
   logic          o_m_pslverr;
   logic          o_s_psel, o_s_penable, o_s_pwrite;
   logic [AW-1:0] o_s_paddr;
   logic [DW-1:0] o_s_pwdata;
   logic [SW-1:0] o_s_pstrb;
   logic [2:0]    o_s_pprot;
   logic          i_s_pready;
   logic [DW-1:0] i_s_prdata;
   logic          i_s_pslverr;
   logic [1:0]    o_grant;

   apb_bus1_arbiter #(.ADDR_BITS(AW), .DATA_BITS(DW), .TIMEOUT_CYCLES(TO)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_m_psel(i_m_psel), .i_m_penable(i_m_penable), .i_m_paddr(i_m_paddr),
      .i_m_pwrite(i_m_pwrite), .i_m_pwdata(i_m_pwdata), .i_m_pstrb(i_m_pstrb),
      .i_m_pprot(i_m_pprot),
      .o_m_pready(o_m_pready), .o_m_prdata(o_m_prdata), .o_m_pslverr(o_m_pslverr),
      .o_s_psel(o_s_psel), .o_s_penable(o_s_penable), .o_s_pwrite(o_s_pwrite),
      .o_s_paddr(o_s_paddr), .o_s_pwdata(o_s_pwdata), .o_s_pstrb(o_s_pstrb),
      .o_s_pprot(o_s_pprot),
      .i_s_pready(i_s_pready), .i_s_prdata(i_s_prdata), .i_s_pslverr(i_s_pslverr),
      .o_grant(o_grant)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   // scoreboard of expected completions
   typedef struct {
      logic [1:0]    port;
      logic [DW-1:0] rdata;
      logic          err;
   } exp_t;
   exp_t sb_q[$];

   task automatic push_exp(input logic [1:0] port, input logic [DW-1:0] rd, input logic err);
      exp_t e;
      e.port  = port;
      e.rdata = rd;
      e.err   = err;
      sb_q.push_back(e);
   endtask

   int pcnt0 = 0;
   int pcnt1 = 0;

   // monitor: every cycle with a pready pulse pops one expected completion
   initial begin
      exp_t e;
      forever begin
         @(negedge i_clk);
         if (!i_rst && o_m_pready != 2'b00) begin
            if (o_m_pready[0]) pcnt0++;
            if (o_m_pready[1]) pcnt1++;
            if (sb_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_pready actual=%b required=none", o_m_pready);
            end else begin
               e = sb_q.pop_front();
               check("pready_port", 64'(o_m_pready), 64'(e.port));
               check("prdata", 64'(o_m_prdata), 64'(e.rdata));
               check("pslverr", 64'(o_m_pslverr), 64'(e.err));
            end
         end
      end
   end

   // grant logger: records each new owner as it appears
   logic [1:0] glog[$];
   initial begin
      logic [1:0] prev;
      prev = 2'b00;
      forever begin
         @(negedge i_clk);
         if (o_grant != 2'b00 && prev == 2'b00) glog.push_back(o_grant);
         prev = o_grant;
      end
   end

   // behavioural slave: pready after slv_waits ACCESS cycles, data = base + addr[7:0]
   int            slv_waits = 0;
   bit            slv_never = 1'b0;
   logic [DW-1:0] slv_base  = '0;
   logic          slv_err   = 1'b0;
   initial begin
      int acc;
      acc = 0;
      i_s_pready  = 1'b0;
      i_s_prdata  = '0;
      i_s_pslverr = 1'b0;
      forever begin
         @(negedge i_clk);
         if (o_s_psel && o_s_penable) begin
            if (!slv_never && acc == slv_waits) begin
               i_s_pready  = 1'b1;
               i_s_prdata  = slv_base + {24'h0, o_s_paddr[7:0]};
               i_s_pslverr = slv_err;
            end else begin
               i_s_pready  = 1'b0;
               i_s_prdata  = 32'hDEAD_BEEF;
               i_s_pslverr = 1'b1;
            end
            acc++;
         end else begin
            i_s_pready  = 1'b0;
            i_s_pslverr = 1'b0;
            acc = 0;
         end
      end
   end

   task automatic drive_req(input int p, input logic [AW-1:0] addr, input logic wr,
                            input logic [DW-1:0] wd, input logic [SW-1:0] st, input logic [2:0] pr);
      i_m_psel[p]           = 1'b1;
      i_m_penable[p]        = 1'b0;
      i_m_pwrite[p]         = wr;
      i_m_paddr[p*AW +: AW] = addr;
      i_m_pwdata[p*DW +: DW] = wd;
      i_m_pstrb[p*SW +: SW] = st;
      i_m_pprot[p*3 +: 3]   = pr;
   endtask

   // one APB transfer from master p; a missing pready within the budget is a failure
   task automatic do_xfer(input int p, input logic [AW-1:0] addr, input logic wr,
                          input logic [DW-1:0] wd, input logic [SW-1:0] st, input logic [2:0] pr);
      bit done;
      done = 1'b0;
      @(negedge i_clk);
      drive_req(p, addr, wr, wd, st, pr);
      for (int k = 0; k < 60; k++) begin
         @(negedge i_clk);
         i_m_penable[p] = 1'b1;
         if (o_m_pready[p]) begin
            done = 1'b1;
            break;
         end
      end
      i_m_psel[p]    = 1'b0;
      i_m_penable[p] = 1'b0;
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL xfer_timeout port=%0d addr=0x%0h actual=no_pready required=pready", p, addr);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_s_outputs"}, 64'({o_s_psel, o_s_penable, o_s_pwrite, |o_s_paddr,
                                       |o_s_pwdata, |o_s_pstrb, |o_s_pprot}), 64'h0);
      check({tag, "_m_outputs"}, 64'({o_m_pready, o_m_pslverr, |o_m_prdata}), 64'h0);
      check({tag, "_grant"}, 64'(o_grant), 64'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "bench time limit");
   end

   initial begin
      int k, pen, bad, p0, p1;
      bit stable;
      i_rst = 1'b1;
      i_m_psel = '0; i_m_penable = '0; i_m_pwrite = '0;
      i_m_paddr = '0; i_m_pwdata = '0; i_m_pstrb = '0; i_m_pprot = '0;
      repeat (3) @(negedge i_clk);
      check_all_zero("reset");
      i_rst = 1'b0;
      @(negedge i_clk);

      // 1: m0 read, zero-wait slave, cycle-exact latency
      slv_waits = 0; slv_base = 32'hCAFE_0001; slv_err = 1'b0;
      push_exp(2'b01, 32'hCAFE_0001, 1'b0);
      fork
         do_xfer(0, 32'h1000, 1'b0, 32'h0, 4'h0, 3'b000);
         begin
            @(negedge i_clk);
            @(negedge i_clk);
            check("t1_psel_n", 64'(o_s_psel), 64'h0);
            check("t1_grant_n", 64'(o_grant), 64'h1);
            @(negedge i_clk);
            check("t1_setup", 64'({o_s_psel, o_s_penable}), 64'h2);
            check("t1_paddr", 64'(o_s_paddr), 64'h1000);
            @(negedge i_clk);
            check("t1_access", 64'({o_s_psel, o_s_penable}), 64'h3);
            @(negedge i_clk);
            check("t1_dropped", 64'({o_s_psel, o_s_penable, o_m_pready}), 64'h0);
            @(negedge i_clk);
            check("t1_pready_n4", 64'(o_m_pready), 64'h1);
            @(negedge i_clk);
            check("t1_pready_one", 64'(o_m_pready), 64'h0);
         end
      join

      // 3: m1 write with 3 wait states
      slv_waits = 3; slv_base = 32'h0BAD_0000;
      push_exp(2'b10, 32'h0BAD_0004, 1'b0);
      fork
         do_xfer(1, 32'h2004, 1'b1, 32'h55AA_55AA, 4'hF, 3'b010);
         begin
            k = 0;
            while (!o_s_psel && k < 10) begin @(negedge i_clk); k++; end
            check("t3_setup_pen", 64'(o_s_penable), 64'h0);
            check("t3_grant", 64'(o_grant), 64'h2);
            check("t3_fields", {o_s_paddr, o_s_pwrite, o_s_pstrb, o_s_pprot},
                  {32'h2004, 1'b1, 4'hF, 3'b010});
            check("t3_pwdata", 64'(o_s_pwdata), 64'h55AA_55AA);
            pen = 0; stable = 1'b1;
            @(negedge i_clk);
            while (o_s_penable && pen < 20) begin
               pen++;
               if ({o_s_psel, o_s_paddr, o_s_pwrite, o_s_pwdata, o_s_pstrb, o_s_pprot} !==
                   {1'b1, 32'h2004, 1'b1, 32'h55AA_55AA, 4'hF, 3'b010}) stable = 1'b0;
               @(negedge i_clk);
            end
            check("t3_penable_cycles", 64'(pen), 64'd4);
            check("t3_fields_stable", 64'(stable), 64'h1);
            check("t3_no_early_pready", 64'(o_m_pready), 64'h0);
            @(negedge i_clk);
            check("t3_pready_m1", 64'(o_m_pready), 64'h2);
         end
      join

      // 4: error response then clean response
      slv_waits = 0; slv_base = 32'h0; slv_err = 1'b1;
      push_exp(2'b01, 32'h0000_0010, 1'b1);
      do_xfer(0, 32'h1010, 1'b0, 32'h0, 4'h0, 3'b000);
      slv_err = 1'b0;
      push_exp(2'b10, 32'h0000_0020, 1'b0);
      do_xfer(1, 32'h1020, 1'b0, 32'h0, 4'h0, 3'b000);

      // 5: reset during ACCESS, then a tie goes to port 0
      slv_waits = 20;
      @(negedge i_clk);
      drive_req(0, 32'h1100, 1'b0, 32'h0, 4'h0, 3'b000);
      k = 0;
      while (!o_s_penable && k < 10) begin @(negedge i_clk); k++; end
      check("t5_in_access", 64'(o_s_penable), 64'h1);
      p0 = pcnt0;
      i_rst = 1'b1;
      i_m_psel = 2'b00;
      #1;
      check_all_zero("t5_async");
      @(negedge i_clk);
      i_rst = 1'b0;
      repeat (4) @(negedge i_clk);
      check("t5_no_completion", 64'(pcnt0 - p0), 64'h0);
      slv_waits = 0; slv_base = 32'h7700_0000;
      push_exp(2'b01, 32'h7700_0030, 1'b0);
      push_exp(2'b10, 32'h7700_0040, 1'b0);
      fork
         do_xfer(0, 32'h5030, 1'b0, 32'h0, 4'h0, 3'b001);
         do_xfer(1, 32'h5040, 1'b0, 32'h0, 4'h0, 3'b001);
         begin
            @(negedge i_clk);
            @(negedge i_clk);
            check("t5_tie_grant", 64'(o_grant), 64'h1);
         end
      join

      // 2: both masters contend for 4 rounds each
      slv_base = 32'h1234_0000;
      glog.delete();
      p0 = pcnt0; p1 = pcnt1;
      for (int r = 0; r < 4; r++) begin
         push_exp(2'b01, 32'h1234_0000 + 32'(r * 16), 1'b0);
         push_exp(2'b10, 32'h1234_0008 + 32'(r * 16), 1'b0);
      end
      fork
         for (int r = 0; r < 4; r++) do_xfer(0, 32'h3000 + 32'(r * 16), 1'b0, 32'h0, 4'h0, 3'b000);
         for (int r = 0; r < 4; r++) do_xfer(1, 32'h4008 + 32'(r * 16), 1'b0, 32'h0, 4'h0, 3'b000);
      join
      check("t2_pulses_m0", 64'(pcnt0 - p0), 64'd4);
      check("t2_pulses_m1", 64'(pcnt1 - p1), 64'd4);
      check("t2_grant_count", 64'(glog.size()), 64'd8);
      for (int i = 0; i < 8 && i < glog.size(); i++)
         check($sformatf("t2_grant_%0d", i), 64'(glog[i]), (i % 2 == 0) ? 64'h1 : 64'h2);

      // 6: slave never ready
      slv_never = 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
      push_exp(2'b01, 32'h0, 1'b1);
      fork
         do_xfer(0, 32'h1200, 1'b0, 32'h0, 4'h0, 3'b000);
         begin
            k = 0;
            while (!o_s_penable && k < 10) begin @(negedge i_clk); k++; end
            pen = 0;
            while (o_s_penable && pen < 50) begin pen++; @(negedge i_clk); end
            check("t6_access_cycles", 64'(pen), 64'(TO));
            check("t6_psel_dropped", 64'({o_s_psel, o_m_pready}), 64'h0);
            @(negedge i_clk);
            check("t6_timeout_pready", 64'(o_m_pready), 64'h1);
         end
      join
      slv_never = 1'b0;
`else
      @(negedge i_clk);
      drive_req(0, 32'h1200, 1'b0, 32'h0, 4'h0, 3'b000);
      k = 0;
      while (!o_s_penable && k < 10) begin @(negedge i_clk); k++; end
      bad = 0;
      for (int c = 0; c < 1000; c++) begin
         @(negedge i_clk);
         if (o_m_pready != 2'b00 || !o_s_penable || !o_s_psel) bad++;
      end
      check("t6_wait_persists", 64'(bad), 64'h0);
      i_rst = 1'b1;
      i_m_psel = 2'b00;
      slv_never = 1'b0;
      @(negedge i_clk);
      i_rst = 1'b0;
      @(negedge i_clk);
`endif
      // recovery transfer after the hung one
      slv_waits = 1; slv_base = 32'hA5A5_0000;
      push_exp(2'b10, 32'hA5A5_0044, 1'b0);
      do_xfer(1, 32'h6044, 1'b0, 32'h0, 4'h0, 3'b000);
      repeat (3) @(negedge i_clk);
      check("sb_empty", 64'(sb_q.size()), 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
